// File: rtl/coproc_ctrl_mc.sv
// Multi-channel coprocessor control/status block: per-core go, sticky host interrupt,
// gpu_irq0 pulse and a single-step handshake FSM, with a shared status read-back mux.
module coproc_ctrl_mc #(
    parameter int          NCH     = 2,
    parameter int          SELW    = 1,
    parameter logic [3:0]  VERSION = 4'h2
) (
    input  logic            sys_clk,
    input  logic            reset_n,
    input  logic            ctrlwr,
    input  logic [SELW-1:0] ctrl_sel,
    input  logic [31:0]     ctrl_din,
    input  logic            statrd,
    input  logic [SELW-1:0] stat_sel,
    input  logic [NCH-1:0]  core_stop,
    input  logic [NCH-1:0]  single_stop,
    output logic [15:0]     stat_dout,
    output logic            stat_oe,
    output logic [NCH-1:0]  go,
    output logic [NCH-1:0]  bus_hog,
    output logic [NCH-1:0]  single_step,
    output logic [NCH-1:0]  single_go,
    output logic [NCH-1:0]  gpu_irq0,
    output logic [NCH-1:0]  cpu_int_pend,
    output logic            cpu_int
);

    // state  | meaning
    // S_OFF  | step mode disabled, core free-running under go
    // S_HALT | step mode, waiting for a step command
    // S_STEP | single_go pulse cycle
    // S_WAIT | step issued, waiting for the core's single_stop
    typedef enum logic [1:0] {S_OFF, S_HALT, S_STEP, S_WAIT} step_state_e;

    step_state_e          state_q [NCH];
    step_state_e          state_d [NCH];
    logic [NCH-1:0]       go_q, go_d;
    logic [NCH-1:0]       hog_q, hog_d;
    logic [NCH-1:0]       int_en_q, int_en_d;
    logic [NCH-1:0]       pend_q, pend_d;
    logic [NCH-1:0]       irq0_q, irq0_d;
    logic [NCH-1:0]       wr_hit;

    logic unused_din;
    assign unused_din = ^{ctrl_din[31:12], ctrl_din[10:7]};

    // Out-of-range selects match no channel because the loop index never reaches them.
    always_comb begin
        wr_hit   = '0;
        go_d     = go_q;
        hog_d    = hog_q;
        int_en_d = int_en_q;
        pend_d   = pend_q;
        irq0_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = ctrlwr && (ctrl_sel == SELW'(i));
            if (wr_hit[i]) begin
                go_d[i]     = ctrl_din[0];
                hog_d[i]    = ctrl_din[11];
                int_en_d[i] = ctrl_din[6];
                irq0_d[i]   = ctrl_din[2];
                if (ctrl_din[1])
                    pend_d[i] = 1'b1;
                else if (ctrl_din[5])
                    pend_d[i] = 1'b0;
            end else if (core_stop[i]) begin
                go_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_OFF:  if (wr_hit[i] && ctrl_din[3]) state_d[i] = S_HALT;
                S_HALT: if (wr_hit[i] && ctrl_din[3] && ctrl_din[4]) state_d[i] = S_STEP;
                S_STEP: state_d[i] = single_stop[i] ? S_HALT : S_WAIT;
                S_WAIT: if (single_stop[i]) state_d[i] = S_HALT;
                default: state_d[i] = S_OFF;
            endcase
            if (wr_hit[i] && !ctrl_din[3])
                state_d[i] = S_OFF;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q     <= '0;
            hog_q    <= '0;
            int_en_q <= '0;
            pend_q   <= '0;
            irq0_q   <= '0;
            for (int i = 0; i < NCH; i++)
                state_q[i] <= S_OFF;
        end else begin
            go_q     <= go_d;
            hog_q    <= hog_d;
            int_en_q <= int_en_d;
            pend_q   <= pend_d;
            irq0_q   <= irq0_d;
            for (int i = 0; i < NCH; i++)
                state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        single_step = '0;
        single_go   = '0;
        stat_dout   = {VERSION, 12'h000};
        for (int i = 0; i < NCH; i++) begin
            single_step[i] = (state_q[i] != S_OFF);
            single_go[i]   = (state_q[i] == S_STEP);
            if (stat_sel == SELW'(i))
                stat_dout = {VERSION, hog_q[i], 4'b0000, int_en_q[i], pend_q[i],
                             (state_q[i] == S_STEP) || (state_q[i] == S_WAIT),
                             (state_q[i] == S_HALT), 2'b00, go_q[i]};
        end
    end

    assign go           = go_q;
    assign bus_hog      = hog_q;
    assign gpu_irq0     = irq0_q;
    assign cpu_int_pend = pend_q;
    assign cpu_int      = |(pend_q & int_en_q);
    assign stat_oe      = statrd;

endmodule

// File: doc/coproc_ctrl_mc.md
Name: coproc_ctrl_mc

Overview:
Parametrised multi-channel control/status register block for the RISC coprocessors (GPU/DSP class). It generalises the single-core control register to NCH independently addressed cores. Each channel has:
- a go bit that the core can clear itself (self-halt);
- a sticky, maskable CPU interrupt with explicit clear;
- a single-step state machine with a proper step handshake.

It sits between the host register decoder and the coprocessor cores. It drives a shared read-back status bus.

Parameters:
NCH, 2, number of coprocessor channels (1..16)
SELW, 1, channel-select width; NCH <= 2**SELW
VERSION, 4'h2, constant returned in status bits 15:12

Ports:
sys_clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
ctrlwr  in  1  control-register write strobe, one cycle per write
ctrl_sel  in  SELW  channel addressed by ctrlwr
ctrl_din  in  32  write data
statrd  in  1  status read strobe
stat_sel  in  SELW  channel addressed by statrd
core_stop  in  NCH  per-core self-halt pulse (core clears its own go)
single_stop  in  NCH  per-core "stepped instruction retired" pulse
stat_dout  out  16  status word of channel stat_sel
stat_oe  out  1  = statrd (tristate enable for the shared data bus)
go  out  NCH  per-core run enable
bus_hog  out  NCH  per-core bus priority request
single_step  out  NCH  per-core step mode active
single_go  out  NCH  one-cycle step pulse
gpu_irq0  out  NCH  one-cycle interrupt-0 pulse to the core
cpu_int_pend  out  NCH  sticky host-interrupt pending flags
cpu_int  out  1  OR over channels of (pend & int_en)

Behaviour:
- All outputs are registered except stat_dout, stat_oe and cpu_int, which are combinational.
- Reset: every register clears to 0 (go, bus_hog, int_en, pend, gpu_irq0, single_go) and every FSM goes to S_OFF.
- Reset is asynchronous and takes effect immediately, including in the middle of a step or a pending interrupt.
- A write affects only the channel with ctrl_sel == index. If ctrl_sel >= NCH the write is ignored.
- Write fields: bit0 go, bit1 raise cpu_int, bit2 gpu_irq0, bit3 step-mode, bit4 step, bit5 clear cpu_int, bit6 int_en, bit11 bus_hog.
- go:
  - Write loads ctrl_din[0].
  - A core_stop pulse clears go.
  - If a write and core_stop occur in the same cycle, the write wins.
  - Latency: the write is visible on go on the next edge.
- bus_hog, int_en: loaded from bits 11 and 6 on every write to the channel.
- gpu_irq0: pulses for exactly one cycle after a write with bit2=1. Consecutive writes give consecutive pulses.
- pend:
  - Set by a write with bit1=1.
  - Cleared by a write with bit5=1.
  - If bit1 and bit5 are both set in one write, the set wins.
  - pend is independent of int_en.
- cpu_int = OR over i of (pend[i] & int_en[i]).
- Single-step FSM (one per channel). States: S_OFF, S_HALT, S_STEP, S_WAIT.
  - Any state: a write with bit3=0 goes to S_OFF (abort; single_go is deasserted the next cycle).
  - S_OFF: a write with bit3=1 goes to S_HALT.
  - S_HALT: a write with bit3=1 and bit4=1 goes to S_STEP.
  - S_STEP: single_go=1 for this one cycle only. Go to S_WAIT, or directly to S_HALT if single_stop is seen in this cycle.
  - S_WAIT: single_stop goes to S_HALT. A step write in S_WAIT is ignored (not queued).
  - single_step = (state != S_OFF). single_go = (state == S_STEP).
  - single_stop in S_OFF or S_HALT is ignored.
- Status word for channel stat_sel:
  - bit0 go
  - bit3 halted (S_HALT)
  - bit4 stepping (S_STEP or S_WAIT)
  - bit5 pend
  - bit6 int_en
  - bit11 bus_hog
  - bits 15:12 VERSION
  - all other bits 0
  - If stat_sel >= NCH, stat_dout = {VERSION, 12'h0}.
- Reading status has no side effects.

Test Plan:
- Reset: pulse reset_n low mid-cycle → all outputs 0 immediately; stat_dout of ch0 reads 16'h2000.
- go: write ch1 din=0x0001 → go=2'b10 next cycle. Pulse core_stop[1] → go[1]=0. Write go=1 together with core_stop[1] in the same cycle → go[1]=1.
- Step handshake: write ch0 0x0008 → single_step[0]=1, status 0x2008. Write 0x0018 → single_go[0] high for exactly 1 cycle, status 0x2010. A second 0x0018 in S_WAIT produces no pulse. single_stop[0] → status returns to 0x2008. Write 0x0000 → single_step[0]=0.
- Interrupt: write ch1 0x0002 → cpu_int_pend=2'b10, cpu_int=0. Write 0x0040 → cpu_int=1. Write 0x0060 → pend cleared, cpu_int=0. Write 0x0022 → pend remains 1.
- gpu_irq0 and channel isolation: write ch0 0x0004 on two consecutive cycles → gpu_irq0[0] high for 2 cycles, ch1 unchanged. Write with ctrl_sel=3, NCH=2, SELW=2 → no state change; status read of sel 3 gives 0x2000.
- Reset mid-step: assert reset_n low while in S_WAIT → FSM returns to S_OFF and single_go stays 0.
